// File: rtl/cpu_pkg.sv
// Shared types for the sequencer: FSM state encoding and the stage that
// follows EXEC for a given decoder class.
package cpu_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5,
      ERR    = 3'd6
   } state_e;

   localparam logic [1:0] CLS_RETIRE = 2'd0;
   localparam logic [1:0] CLS_WB     = 2'd1;
   localparam logic [1:0] CLS_MEM    = 2'd2;

   // Memory access takes precedence over a plain register writeback.
   function automatic logic [1:0] exec_class(input logic load,
                                             input logic store,
                                             input logic wb);
      if (load || store) return CLS_MEM;
      if (wb)            return CLS_WB;
      return CLS_RETIRE;
   endfunction

endpackage

// File: rtl/cpu_seq_if.sv
// Instruction- and data-memory handshake bundle between the sequencer
// (master) and the memory side (slave).
interface cpu_seq_if #(
   parameter int PC_W   = 16,
   parameter int DATA_W = 16
);
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic              dmem_req;
   logic              dmem_we;
   logic              dmem_ack;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we,
      input  imem_ack, imem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we,
      output imem_ack, imem_rdata, dmem_ack
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for a memory acknowledge. expired pulses on
// the cycle that would complete TIMEOUT waits; an ack in that cycle wins.
module mem_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic clear,
   input  logic tick,
   input  logic ack,
   output logic expired
);

   localparam int          CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit          EN   = (TIMEOUT != 0);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (tick && !ack) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign expired = EN && tick && !ack && (cnt_q == LAST);

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback
// control with PC, instruction latch and a saturating retire counter.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   FETCH  | imem_req high, waiting for imem_ack to latch ir
//   DECODE | one cycle, id_en; dec_hlt diverts to HALT
//   EXEC   | one cycle, ex_en; picks MEM, WB or retire
//   MEM    | dmem_req high, waiting for dmem_ack
//   WB     | one cycle, rf_we, then retire
//   HALT   | absorbing, hlt
//   ERR    | absorbing, hlt and err (memory acknowledge timeout)
module cpu_seq
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter int              DATA_W   = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              TIMEOUT  = 16,
   parameter int              CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   cpu_seq_if.master         mem_if,
   input  logic              dec_load,
   input  logic              dec_store,
   input  logic              dec_wb,
   input  logic              dec_hlt,
   input  logic              alt_pc_ctrl,
   input  logic [PC_W-1:0]   alt_pc,
   output logic [DATA_W-1:0] ir,
   output logic [PC_W-1:0]   pc,
   output logic              id_en,
   output logic              ex_en,
   output logic              rf_we,
   output logic              hlt,
   output logic              err,
   output logic [CNT_W-1:0]  retired
);

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [CNT_W-1:0]    ret_q, ret_d;
   logic                retire;
   logic                imem_req;
   logic                dmem_req;
   logic                dmem_we;
   logic                wait_clear;
   logic                wait_tick;
   logic                wait_ack;
   logic                expired;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      ret_d    = ret_q;
      retire   = 1'b0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      id_en    = 1'b0;
      ex_en    = 1'b0;
      rf_we    = 1'b0;
      hlt      = 1'b0;
      err      = 1'b0;
      unique case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            if (mem_if.imem_ack) begin
               ir_d    = mem_if.imem_rdata;
               state_d = DECODE;
            end else if (expired) begin
               state_d = ERR;
            end
         end
         DECODE: begin
            id_en   = 1'b1;
            state_d = dec_hlt ? HALT : EXEC;
         end
         EXEC: begin
            ex_en = 1'b1;
            unique case (exec_class(dec_load, dec_store, dec_wb))
               CLS_MEM: state_d = MEM;
               CLS_WB:  state_d = WB;
               default: retire  = 1'b1;
            endcase
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = dec_store;
            if (mem_if.dmem_ack) begin
               if (dec_load) state_d = WB;
               else          retire  = 1'b1;
            end else if (expired) begin
               state_d = ERR;
            end
         end
         WB: begin
            rf_we  = 1'b1;
            retire = 1'b1;
         end
         HALT: begin
            hlt = 1'b1;
         end
         ERR: begin
            hlt = 1'b1;
            err = 1'b1;
         end
         default: state_d = ERR;
      endcase
      if (retire) begin
         pc_d    = alt_pc_ctrl ? alt_pc : pc_q + PC_W'(1);
         ret_d   = (&ret_q) ? ret_q : ret_q + CNT_W'(1);
         state_d = FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ret_q   <= ret_d;
      end
   end

   // The wait count restarts whenever a new handshake state is entered.
   assign wait_tick  = (state_q == FETCH) || (state_q == MEM);
   assign wait_ack   = (state_q == FETCH) ? mem_if.imem_ack :
                       (state_q == MEM)   ? mem_if.dmem_ack : 1'b0;
   assign wait_clear = rst || ((state_d != state_q) &&
                               ((state_d == FETCH) || (state_d == MEM)));

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait (
      .clk     (clk),
      .clear   (wait_clear),
      .tick    (wait_tick),
      .ack     (wait_ack),
      .expired (expired)
   );

   assign mem_if.imem_req  = imem_req;
   assign mem_if.imem_addr = pc_q;
   assign mem_if.dmem_req  = dmem_req;
   assign mem_if.dmem_we   = dmem_we;
   assign ir               = ir_q;
   assign pc               = pc_q;
   assign retired          = ret_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq: per-instruction cycle expectations built from
// the instruction class and handshake delays, checked every cycle.
module tb_cpu_seq;

   localparam int TO = 4;
   localparam int CW = 3;
   localparam int P_PC = 0, P_RET = 1, P_IR = 2, P_ADDR = 3;
   localparam int P_ERR = 4, P_HLT = 5, P_IREQ = 6, P_RFWE = 7;

   logic        clk = 1'b0;
   logic        rst;
   logic        dec_load, dec_store, dec_wb, dec_hlt, alt_pc_ctrl;
   logic [15:0] alt_pc;
   logic [15:0] ir, pc;
   logic        id_en, ex_en, rf_we, hlt, err;
   logic [CW-1:0] retired;

   cpu_seq_if #(.PC_W(16), .DATA_W(16)) bus ();

   cpu_seq #(
      .PC_W(16), .DATA_W(16), .RESET_PC(16'h0000), .TIMEOUT(TO), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .mem_if(bus),
      .dec_load(dec_load), .dec_store(dec_store), .dec_wb(dec_wb), .dec_hlt(dec_hlt),
      .alt_pc_ctrl(alt_pc_ctrl), .alt_pc(alt_pc),
      .ir(ir), .pc(pc), .id_en(id_en), .ex_en(ex_en), .rf_we(rf_we),
      .hlt(hlt), .err(err), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          imem_req;
      logic [15:0]   imem_addr;
      logic          dmem_req, dmem_we, id_en, ex_en, rf_we, hlt, err;
      logic [15:0]   pc, ir;
      logic [CW-1:0] retired;
   } exp_t;

   typedef struct {
      string       name;
      int          sel;
      logic [15:0] val;
   } pin_t;

   exp_t        expq[$];
   pin_t        pinq[$];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [15:0] m_pc, m_ir;
   int          m_ret;

   // ---------------- compare process ----------------
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] pinsel(input int sel);
      case (sel)
         P_PC:    return pc;
         P_RET:   return 16'(retired);
         P_IR:    return ir;
         P_ADDR:  return bus.imem_addr;
         P_ERR:   return 16'(err);
         P_HLT:   return 16'(hlt);
         P_IREQ:  return 16'(bus.imem_req);
         default: return 16'(rf_we);
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      pin_t p;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("imem_req", 16'(bus.imem_req), 16'(e.imem_req));
         if (e.imem_req) chk("imem_addr", bus.imem_addr, e.imem_addr);
         chk("dmem_req", 16'(bus.dmem_req), 16'(e.dmem_req));
         chk("dmem_we",  16'(bus.dmem_we),  16'(e.dmem_we));
         chk("id_en",    16'(id_en),        16'(e.id_en));
         chk("ex_en",    16'(ex_en),        16'(e.ex_en));
         chk("rf_we",    16'(rf_we),        16'(e.rf_we));
         chk("hlt",      16'(hlt),          16'(e.hlt));
         chk("err",      16'(err),          16'(e.err));
         chk("pc",       pc,                e.pc);
         chk("ir",       ir,                e.ir);
         chk("retired",  16'(retired),      16'(e.retired));
      end
      while (pinq.size() > 0) begin
         p = pinq.pop_front();
         chk(p.name, pinsel(p.sel), p.val);
      end
   end

   // ---------------- model and stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Inputs that the block must ignore in the current state get hostile values.
   task automatic noise();
      rst            = 1'b0;
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 16'hDEAD;
      bus.dmem_ack   = 1'b1;
      dec_load       = 1'b1;
      dec_store      = 1'b1;
      dec_wb         = 1'b0;
      dec_hlt        = 1'b1;
      alt_pc_ctrl    = 1'b1;
      alt_pc         = 16'hBEEF;
   endtask

   task automatic drive_dec(input logic ld, input logic st, input logic wb, input logic hl);
      dec_load  = ld;
      dec_store = st;
      dec_wb    = wb;
      dec_hlt   = hl;
   endtask

   function automatic exp_t base();
      exp_t e;
      e.imem_req  = 1'b0;
      e.imem_addr = m_pc;
      e.dmem_req  = 1'b0;
      e.dmem_we   = 1'b0;
      e.id_en     = 1'b0;
      e.ex_en     = 1'b0;
      e.rf_we     = 1'b0;
      e.hlt       = 1'b0;
      e.err       = 1'b0;
      e.pc        = m_pc;
      e.ir        = m_ir;
      e.retired   = CW'(m_ret);
      return e;
   endfunction

   task automatic pin(input string n, input int s, input logic [15:0] v);
      pin_t p;
      p.name = n;
      p.sel  = s;
      p.val  = v;
      pinq.push_back(p);
   endtask

   task automatic model_reset();
      m_pc  = 16'h0000;
      m_ir  = 16'h0000;
      m_ret = 0;
   endtask

   task automatic do_reset(input int n);
      noise();
      rst            = 1'b1;
      bus.imem_rdata = 16'h7E7E;
      repeat (n) step();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic absorb(input logic e_err, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         noise();
         e     = base();
         e.hlt = 1'b1;
         e.err = e_err;
         expq.push_back(e);
         step();
      end
   endtask

   // One instruction: fw/mw are the cycles the memory waits before acking;
   // a wait of TO or more means no ack arrives in time.
   task automatic do_instr(input int fw, input logic [15:0] instr,
                           input logic ld, input logic st, input logic wb, input logic hl,
                           input int mw, input logic redir, input logic [15:0] tgt,
                           input bit rst_mem);
      exp_t e;
      bit   mem_op, wb_op;
      mem_op = ld | st;
      wb_op  = ld | (!st & wb);
      for (int k = 0; k <= fw && k < TO; k++) begin
         noise();
         bus.imem_ack   = (k == fw);
         bus.imem_rdata = (k == fw) ? instr : ~instr;
         e = base();
         e.imem_req = 1'b1;
         expq.push_back(e);
         step();
      end
      if (fw >= TO) begin
         absorb(1'b1, 10);
         return;
      end
      m_ir = instr;
      noise();
      drive_dec(ld, st, wb, hl);
      e = base();
      e.id_en = 1'b1;
      expq.push_back(e);
      step();
      if (hl) begin
         absorb(1'b0, 20);
         return;
      end
      noise();
      drive_dec(ld, st, wb, hl);
      if (!mem_op && !wb_op) begin
         alt_pc_ctrl = redir;
         alt_pc      = tgt;
      end
      e = base();
      e.ex_en = 1'b1;
      expq.push_back(e);
      step();
      if (mem_op) begin
         for (int k = 0; k <= mw && k < TO; k++) begin
            noise();
            drive_dec(ld, st, wb, hl);
            bus.dmem_ack = (k == mw);
            if (k == mw && !wb_op) begin
               alt_pc_ctrl = redir;
               alt_pc      = tgt;
            end
            if (rst_mem) begin
               rst          = 1'b1;
               bus.dmem_ack = 1'b1;
            end
            e = base();
            e.dmem_req = 1'b1;
            e.dmem_we  = st;
            expq.push_back(e);
            step();
            if (rst_mem) begin
               rst = 1'b0;
               model_reset();
               return;
            end
         end
         if (mw >= TO) begin
            absorb(1'b1, 10);
            return;
         end
      end
      if (wb_op) begin
         noise();
         alt_pc_ctrl = redir;
         alt_pc      = tgt;
         e = base();
         e.rf_we = 1'b1;
         expq.push_back(e);
         step();
      end
      m_pc = redir ? tgt : m_pc + 16'd1;
      if (m_ret < (1 << CW) - 1) m_ret++;
   endtask

   initial begin
      do_reset(2);
      pin("reset_pc", P_PC, 16'h0000);
      pin("reset_retired", P_RET, 16'd0);
      pin("reset_ir", P_IR, 16'h0000);
      pin("reset_imem_req", P_IREQ, 16'd1);

      // ALU with writeback, ack in the first fetch cycle
      do_instr(0, 16'h1111, 0, 0, 1, 0, 0, 1'b0, 16'h0000, 0);
      pin("alu_pc", P_PC, 16'h0001);
      pin("alu_retired", P_RET, 16'd1);

      // load, dmem ack after 3 wait cycles
      do_instr(0, 16'h2222, 1, 0, 0, 0, 3, 1'b0, 16'h0000, 0);
      pin("load_pc", P_PC, 16'h0002);
      pin("load_retired", P_RET, 16'd2);

      // store with dec_wb also set: still no writeback
      do_instr(1, 16'h3333, 0, 1, 1, 0, 0, 1'b0, 16'h0000, 0);
      pin("store_pc", P_PC, 16'h0003);

      // branch from a no-writeback instruction
      do_instr(0, 16'h4444, 0, 0, 0, 0, 0, 1'b1, 16'h0040, 0);
      pin("branch_addr", P_ADDR, 16'h0040);
      pin("branch_retired", P_RET, 16'd4);

      do_instr(0, 16'h4545, 0, 0, 1, 0, 0, 1'b1, 16'hFFFF, 0);
      pin("jump_pc", P_PC, 16'hFFFF);

      // pc wraps
      do_instr(2, 16'h5555, 0, 0, 1, 0, 0, 1'b0, 16'h0000, 0);
      pin("wrap_pc", P_PC, 16'h0000);

      // ack in the last allowed fetch cycle wins over the timeout
      do_instr(3, 16'h6666, 0, 0, 1, 0, 0, 1'b0, 16'h0000, 0);
      pin("late_ack_ir", P_IR, 16'h6666);
      pin("late_ack_err", P_ERR, 16'd0);
      pin("late_ack_retired", P_RET, 16'd7);

      // retired saturates
      do_instr(0, 16'h7777, 0, 0, 1, 0, 0, 1'b0, 16'h0000, 0);
      pin("sat_retired", P_RET, 16'd7);
      pin("sat_pc", P_PC, 16'h0002);

      // fetch timeout
      do_instr(TO, 16'h0BAD, 0, 0, 1, 0, 0, 1'b0, 16'h0000, 0);
      pin("fto_err", P_ERR, 16'd1);
      pin("fto_hlt", P_HLT, 16'd1);
      pin("fto_pc", P_PC, 16'h0002);

      // reset during MEM with dmem_ack in the same cycle
      do_reset(1);
      do_instr(0, 16'h8888, 1, 0, 1, 0, 0, 1'b0, 16'h0000, 1);
      pin("mrst_pc", P_PC, 16'h0000);
      pin("mrst_retired", P_RET, 16'd0);
      pin("mrst_rf_we", P_RFWE, 16'd0);
      pin("mrst_imem_req", P_IREQ, 16'd1);

      // data-memory timeout on a store
      do_instr(0, 16'h9999, 0, 1, 0, 0, TO + 1, 1'b0, 16'h0000, 0);
      pin("dto_err", P_ERR, 16'd1);
      pin("dto_pc", P_PC, 16'h0000);

      // halt, then reset resumes fetching
      do_reset(1);
      do_instr(0, 16'hAAAA, 0, 0, 0, 1, 0, 1'b0, 16'h0000, 0);
      pin("halt_hlt", P_HLT, 16'd1);
      pin("halt_err", P_ERR, 16'd0);
      pin("halt_imem_req", P_IREQ, 16'd0);
      pin("halt_pc", P_PC, 16'h0000);
      do_reset(1);
      do_instr(0, 16'hBBBB, 0, 0, 1, 0, 0, 1'b0, 16'h0000, 0);
      pin("resume_pc", P_PC, 16'h0001);

      noise();
      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
